// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: LOAD/EXEC/WB control FSM for the 16-bit ALU datapath
module alu_op_sequencer #(
  parameter int unsigned ADD_CYCLES = 1,
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_op,
  input  logic       cmd_src_b,
  output logic       cmd_ready,
  output logic [1:0] a_s,
  output logic [3:0] b_s,
  output logic [5:0] res_sel,
  output logic       acc_we,
  output logic       acc_clr,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, LOAD, EXEC, WB} state_t;
  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_DIV = 3'd6;
  localparam logic [2:0] OP_CLR = 3'd7;
  if (ADD_CYCLES < 1 || ADD_CYCLES > 15 || MUL_CYCLES < 1 || MUL_CYCLES > 15 ||
      DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_cycles
    $error("alu_op_sequencer: *_CYCLES must be in 1..15");
  end
  state_t     state, state_d;
  logic [2:0] op_q, op_d;
  logic       src_q, src_d;
  logic [3:0] cnt_q, cnt_d;
  logic       alu_op;
  logic [3:0] lat_m1;
  // state, latched command and EXEC countdown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= OP_NOP;
      src_q <= 1'b0;
      cnt_q <= 4'd0;
    end else begin
      state <= state_d;
      op_q  <= op_d;
      src_q <= src_d;
      cnt_q <= cnt_d;
    end
  end
  // next-state: accept in IDLE, load latency-1 in LOAD, count down in EXEC
  always_comb begin
    state_d = state;
    op_d    = op_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    alu_op  = op_q != OP_NOP && op_q != OP_CLR;
    lat_m1  = op_q == OP_ADD ? 4'(ADD_CYCLES - 1) :
              op_q == OP_MUL ? 4'(MUL_CYCLES - 1) :
              op_q == OP_DIV ? 4'(DIV_CYCLES - 1) : 4'd0;
    case (state)
      IDLE: if (cmd_valid) begin
        state_d = LOAD;
        op_d    = cmd_op;
        src_d   = cmd_src_b;
      end
      LOAD: begin
        state_d = EXEC;
        cnt_d   = lat_m1;
      end
      EXEC: if (cnt_q == 4'd0) state_d = WB; else cnt_d = cnt_q - 4'd1;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // outputs decoded purely from registered state and latched op
  always_comb begin
    cmd_ready = state == IDLE;
    busy      = state != IDLE;
    done      = state == WB;
    a_s       = (state == LOAD && alu_op) ? 2'b10 : 2'b01;
    b_s       = state != LOAD ? 4'b0001 :
                op_q == OP_CLR ? 4'b1000 :
                op_q == OP_NOP ? 4'b0001 :
                src_q ? 4'b0010 : 4'b0100;
    res_sel   = ((state == EXEC || state == WB) && alu_op) ? 6'b000001 << (op_q - 3'd1) : 6'b0;
    acc_we    = state == WB && alu_op;
    acc_clr   = state == WB && op_q == OP_CLR;
  end
endmodule
